fixed_point_to_ascii: RTL and testbench
=======================================

# fixed_point_to_ascii

Sequential converter from a signed Qm.n fixed-point result to a fixed-width ASCII string (sign, integer digits, dot, fractional digits). It sits between the CORDIC_Algorithm outputs and the Text_Overlay character buffer, in the pixel-clock domain. It replaces elaboration-time-only formatting with a small multi-cycle digit extractor that updates the displayed value whenever the CORDIC produces a new result.

## Interface
Parameters:
- INTEGER_BITS, 3, integer bits of the input including the sign bit.
- FRACTIONAL_BITS, 30, fractional bits of the input.
- INT_DIGITS, 2, decimal integer digits emitted.
- FRAC_DIGITS, 4, decimal fractional digits emitted.
- Derived: BITS = INTEGER_BITS+FRACTIONAL_BITS; CHARS = INT_DIGITS+FRAC_DIGITS+2.

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  pixel clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  i_value is presented for conversion.
- i_value  in  BITS  signed two's-complement fixed-point input.
- o_ready  out  1  converter idle; a conversion starts on i_valid && o_ready.
- o_valid  out  1  one-cycle pulse: o_string has just been updated.
- o_string  out  CHARS*8  ASCII characters, most significant byte = sign character.

## Operation
- String layout, MSB first: sign ("-" if i_value[BITS-1], else "+"), INT_DIGITS integer digits MS-first, ".", FRAC_DIGITS fractional digits. Default: "+dd.dddd".
- Magnitude: BITS-bit unsigned |i_value|; the most negative code converts correctly (e.g. -4.0 → "-04.0000").
- Integer digits: each cycle, int_reg ← int_reg/10, digit ← int_reg%10, filled LS-first. If the integer part ≥ 10^INT_DIGITS, higher digits are dropped (modulo).
- Fractional digits: each cycle, frac_reg×10; the bits above FRACTIONAL_BITS give the digit and the low FRACTIONAL_BITS are kept. Digits are filled MS-first. The default is truncation toward zero.
- Negative values that truncate to zero keep the "-" sign ("-00.0000").
- FSM states: IDLE → PREP (abs, optional rounding) → INT (INT_DIGITS cycles) → FRAC (FRAC_DIGITS cycles) → DONE (one cycle) → IDLE.
- o_string is written only on the edge entering DONE. It is held stable otherwise, so Text_Overlay can sample it at any time.
- i_valid outside IDLE is ignored: no queueing and no error.

## Timing
- Reset: state = IDLE, o_valid = 0, o_string = "+00.0000" (zero-filled for the parameters in use). o_ready = 0 while i_rst is high and 1 from the first cycle after reset is released.
- Accept edge = cycle 0. o_valid is high for exactly one cycle, beginning INT_DIGITS+FRAC_DIGITS+2 cycles after accept (8 with the defaults).
- o_ready deasserts the cycle after accept and reasserts the cycle after o_valid. Throughput is one conversion per INT_DIGITS+FRAC_DIGITS+3 cycles.
- If i_valid is held continuously, a new conversion is accepted on the first IDLE cycle.
- i_rst mid-conversion aborts the conversion. o_valid does not pulse, and o_string returns to its reset value on the next edge.
- Reset takes priority over accept when both occur in the same cycle.

## Configuration
- ROUNDING_EN defined: in PREP, add ROUND_K = 2^FRACTIONAL_BITS / (2·10^FRAC_DIGITS), integer-truncated (53687 with the defaults), to the magnitude. Carries propagate into the integer part. The result is round-half-up on magnitude.
- ROUNDING_EN undefined: pure truncation. Latency is identical in both modes.

## Structure
- Shared package cordic_display_pkg holds:
  - the ASCII constants ("+", "-", ".", "0");
  - the state enum type;
  - the parameterised string typedef reused by Text_Overlay callers.
- One sub-module, mul10_split: combinational ×10 with digit/remainder split for the fractional path. The integer divide-by-10 stays inline (width ≤ INTEGER_BITS).

## Test plan
- i_value = 837518623 (0.78): "+00.7800", o_valid exactly 8 cycles after accept.
- i_value = −1610612736 (−1.5): "-01.5000".
- i_value = 33'h1_0000_0000 (−4.0): "-04.0000". i_value = 0: "+00.0000".
- i_value = 1073698875 (0.99996): "+00.9999" without ROUNDING_EN; "+01.0000" with it.
- i_valid pulsed again 3 cycles after accept, with a different value: ignored. o_string holds the first result, and only one o_valid pulse occurs.
- i_rst asserted at cycle 4 of a conversion: no o_valid, o_string = "+00.0000", and o_ready = 1 one cycle after release.

Source files
------------

// File: rtl/cordic_display_pkg.sv
// ---------------------------------------------------------------------------
// cordic_display_pkg
// Shared definitions for the CORDIC result display path:
//   - ASCII constants used when formatting numbers
//   - FSM state type of the fixed-point to ASCII converter
//   - default display string type reused by Text_Overlay callers
//   - ascii_digit(): 4-bit decimal digit to ASCII character
// ---------------------------------------------------------------------------
package cordic_display_pkg;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_INT,
    ST_FRAC,
    ST_DONE
  } conv_state_t;

  // Default display width: sign + 2 integer digits + dot + 4 fractional digits.
  localparam int DISP_CHARS = 8;
  typedef logic [DISP_CHARS*8-1:0] disp_str_t;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'b0000, d};
  endfunction

endpackage

// File: rtl/fixed_point_to_ascii_mul10_split.sv
// ---------------------------------------------------------------------------
// mul10_split
// Combinational x10 of an unsigned binary fraction, split into the decimal
// digit that spills above the binary point and the remaining fraction.
// Ports:
//   frac_i  [FRAC_W-1:0]  fraction (value = frac_i / 2^FRAC_W)
//   digit_o [3:0]         integer part of frac_i*10 (0..9)
//   rem_o   [FRAC_W-1:0]  fractional part of frac_i*10
// ---------------------------------------------------------------------------
module mul10_split #(
  parameter int FRAC_W = 30
) (
  input  logic [FRAC_W-1:0] frac_i,
  output logic [3:0]        digit_o,
  output logic [FRAC_W-1:0] rem_o
);

  logic [FRAC_W+3:0] prod;

  // x10 as x8 + x2; four extra bits hold the digit (max 9).
  assign prod    = ({4'b0000, frac_i} << 3) + ({4'b0000, frac_i} << 1);
  assign digit_o = prod[FRAC_W+3:FRAC_W];
  assign rem_o   = prod[FRAC_W-1:0];

endmodule

// File: rtl/fixed_point_to_ascii.sv
// ---------------------------------------------------------------------------
// fixed_point_to_ascii
// Multi-cycle converter from a signed Q(INTEGER_BITS).(FRACTIONAL_BITS)
// value to a fixed-width ASCII string "+dd.dddd" (sign, INT_DIGITS integer
// digits, dot, FRAC_DIGITS fractional digits).
// FSM: IDLE -> PREP (abs, optional rounding) -> INT x INT_DIGITS
//      -> FRAC x FRAC_DIGITS -> DONE -> IDLE.
// Ports:
//   i_clk     pixel clock, rising edge
//   i_rst     synchronous active-high reset (aborts any conversion)
//   i_valid   i_value presented; accepted when o_ready is high
//   i_value   [BITS-1:0] signed two's-complement fixed-point input
//   o_ready   idle and out of reset
//   o_valid   one-cycle pulse, o_string has just been updated
//   o_string  [CHARS*8-1:0] ASCII result, MS byte = sign character
// Build option: define ROUNDING_EN for round-half-up on the magnitude;
// otherwise fractional digits are truncated. Latency is identical.
// ---------------------------------------------------------------------------
module fixed_point_to_ascii
  import cordic_display_pkg::*;
#(
  parameter int INTEGER_BITS    = 3,
  parameter int FRACTIONAL_BITS = 30,
  parameter int INT_DIGITS      = 2,
  parameter int FRAC_DIGITS     = 4,
  localparam int BITS  = INTEGER_BITS + FRACTIONAL_BITS,
  localparam int CHARS = INT_DIGITS + FRAC_DIGITS + 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [BITS-1:0]   i_value,
  output logic              o_ready,
  output logic              o_valid,
  output logic [CHARS*8-1:0] o_string
);

  // Integer work register is at least 4 bits so the constant 10 fits.
  localparam int IW   = (INTEGER_BITS > 4) ? INTEGER_BITS : 4;
  localparam int MAXD = (INT_DIGITS > FRAC_DIGITS) ? INT_DIGITS : FRAC_DIGITS;
  localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

`ifdef ROUNDING_EN
  // Half of one unit in the last emitted decimal place.
  localparam longint unsigned ROUND_K =
    (64'd1 << FRACTIONAL_BITS) / (64'd2 * 64'(10 ** FRAC_DIGITS));
`endif

  conv_state_t                state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [BITS-1:0]            val_q, val_d;
  logic [IW-1:0]              int_q, int_d;
  logic [FRACTIONAL_BITS-1:0] frac_q, frac_d;
  logic [INT_DIGITS*4-1:0]    idig_q, idig_d;   // digit k = 10^k place
  logic [FRAC_DIGITS*4-1:0]   fdig_q, fdig_d;   // digit j = 10^-(j+1) place
  logic [CHARS*8-1:0]         str_q, str_d;
  logic                       valid_q, valid_d;

  logic [BITS-1:0]            mag_abs;
  logic [BITS-1:0]            mag;
  logic [3:0]                 m_digit;
  logic [FRACTIONAL_BITS-1:0] m_rem;

  // Assemble the display string from sign and BCD digit vectors.
  function automatic logic [CHARS*8-1:0] fmt(
    input logic                    neg,
    input logic [INT_DIGITS*4-1:0] idig,
    input logic [FRAC_DIGITS*4-1:0] fdig
  );
    logic [CHARS*8-1:0] s;
    s = '0;
    s[(CHARS-1)*8 +: 8] = neg ? ASCII_MINUS : ASCII_PLUS;
    for (int k = 0; k < INT_DIGITS; k++) begin
      s[(FRAC_DIGITS+1+k)*8 +: 8] = ascii_digit(idig[k*4 +: 4]);
    end
    s[FRAC_DIGITS*8 +: 8] = ASCII_DOT;
    for (int j = 0; j < FRAC_DIGITS; j++) begin
      s[(FRAC_DIGITS-1-j)*8 +: 8] = ascii_digit(fdig[j*4 +: 4]);
    end
    return s;
  endfunction

  // Two's-complement magnitude; the most negative code maps to 2^(BITS-1),
  // which still fits as an unsigned BITS-wide value.
  assign mag_abs = val_q[BITS-1] ? (~val_q + BITS'(1)) : val_q;

`ifdef ROUNDING_EN
  assign mag = mag_abs + BITS'(ROUND_K);
`else
  assign mag = mag_abs;
`endif

  mul10_split #(
    .FRAC_W (FRACTIONAL_BITS)
  ) u_mul10 (
    .frac_i  (frac_q),
    .digit_o (m_digit),
    .rem_o   (m_rem)
  );

  assign o_ready  = (state_q == ST_IDLE) && !i_rst;
  assign o_valid  = valid_q;
  assign o_string = str_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    int_d   = int_q;
    frac_d  = frac_q;
    idig_d  = idig_q;
    fdig_d  = fdig_q;
    str_d   = str_q;
    valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          val_d   = i_value;
          state_d = ST_PREP;
        end
      end

      ST_PREP: begin
        int_d   = IW'(mag[BITS-1:FRACTIONAL_BITS]);
        frac_d  = mag[FRACTIONAL_BITS-1:0];
        idig_d  = '0;
        fdig_d  = '0;
        cnt_d   = '0;
        state_d = ST_INT;
      end

      ST_INT: begin
        // LS digit first; digits beyond INT_DIGITS are simply never emitted.
        idig_d[4*int'(cnt_q) +: 4] = 4'(int_q % IW'(10));
        int_d = int_q / IW'(10);
        if (cnt_q == CW'(INT_DIGITS - 1)) begin
          cnt_d   = '0;
          state_d = ST_FRAC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_FRAC: begin
        fdig_d[4*int'(cnt_q) +: 4] = m_digit;
        frac_d = m_rem;
        if (cnt_q == CW'(FRAC_DIGITS - 1)) begin
          // The last digit is produced on this same edge, so format from
          // the next-state digit vector.
          str_d   = fmt(val_q[BITS-1], idig_q, fdig_d);
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      int_q   <= '0;
      frac_q  <= '0;
      idig_q  <= '0;
      fdig_q  <= '0;
      str_q   <= fmt(1'b0, '0, '0);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      idig_q  <= idig_d;
      fdig_q  <= fdig_d;
      str_q   <= str_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fixed_point_to_ascii.sv
// ---------------------------------------------------------------------------
// tb_fixed_point_to_ascii
// Directed vectors with hand-computed strings. The stimulus process pushes
// the expected string when it presents a value; the monitor records each
// handshake cycle and, on every o_valid pulse, pops and compares the string
// and the latency (o_valid seen 8 cycles after the handshake cycle).
// ---------------------------------------------------------------------------
module tb_fixed_point_to_ascii;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [32:0] value;
  logic        o_ready;
  logic        o_valid;
  logic [63:0] o_string;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int n_valid = 0;

  logic [63:0] exp_q[$];
  int          acc_q[$];
  logic [63:0] mon_exp;
  int          mon_acc;

  localparam logic [63:0] S_ZERO = "+00.0000";

  always #5 clk = ~clk;

  fixed_point_to_ascii dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (valid),
    .i_value  (value),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_string (o_string)
  );

  task automatic check_str(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" required \"%s\"", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      acc_q.delete();
    end else if (valid && o_ready) begin
      acc_q.push_back(cyc);
    end
    if (o_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 string \"%s\" required no pulse", o_string);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_acc = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        check_str("string", o_string, mon_exp);
        check_int("latency", cyc - mon_acc, 8);
        $display("conv: string \"%s\" latency %0d", o_string, cyc - mon_acc);
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!o_ready && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (!o_ready) begin
      errors++;
      $display("FAIL ready_timeout: got o_ready=0 required 1 within 100 cycles");
    end
  endtask

  task automatic send(input logic [32:0] v, input logic [63:0] e);
    wait_ready();
    exp_q.push_back(e);
    valid = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int g;
    rst   = 1'b1;
    valid = 1'b0;
    value = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_int("ready_in_reset", int'(o_ready), 0);
    check_int("valid_in_reset", int'(o_valid), 0);
    check_str("string_in_reset", o_string, S_ZERO);
    rst = 1'b0;
    #1;
    check_int("ready_after_reset", int'(o_ready), 1);

    // Main function
    send(33'd837518623, "+00.7800");
    send(33'h1_A000_0000, "-01.5000");
    send(33'h1_0000_0000, "-04.0000");
    send(33'd0, "+00.0000");
`ifdef ROUNDING_EN
    send(33'd1073698875, "+01.0000");
    send(33'h0_FFFF_FFFF, "+04.0000");
`else
    send(33'd1073698875, "+00.9999");
    send(33'h0_FFFF_FFFF, "+03.9999");
`endif
    send(33'h0_9000_0000, "+02.2500");
    send(-33'sd10737, "-00.0000");

    // i_valid while busy is ignored
    wait_ready();
    pulses = n_valid;
    exp_q.push_back("+02.2500");
    valid = 1'b1;
    value = 33'h0_9000_0000;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_int("ready_busy", int'(o_ready), 0);
    valid = 1'b1;
    value = 33'h1_A000_0000;
    @(posedge clk);
    #1;
    valid = 1'b0;
    wait_ready();
    repeat (12) @(posedge clk);
    #1;
    check_int("busy_pulses", n_valid - pulses, 1);
    check_str("busy_hold", o_string, "+02.2500");

    // Reset mid-conversion aborts it
    wait_ready();
    pulses = n_valid;
    valid = 1'b1;
    value = 33'h1_A000_0000;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_int("ready_abort_rst", int'(o_ready), 0);
    @(posedge clk);
    #1;
    check_str("abort_string", o_string, S_ZERO);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_int("abort_ready", int'(o_ready), 1);
    repeat (12) @(posedge clk);
    #1;
    check_int("abort_pulses", n_valid - pulses, 0);
    check_str("abort_hold", o_string, S_ZERO);

    // Normal operation resumes
    send(33'd837518623, "+00.7800");

    g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
